// File: rtl/led_matrix_scan_driver.sv
// Column-scan LED matrix driver: double-buffered rows, blanked column mux.
// Optional MATRIX_DIM_EN adds a bright[2:0] input for per-column row dimming.
module led_matrix_scan_driver #(
  parameter int N_COLS    = 5,
  parameter int N_ROWS    = 7,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              wr_en,
  input  logic [2:0]        wr_col,
  input  logic [N_ROWS-1:0] wr_rows,
  input  logic              commit,
`ifdef MATRIX_DIM_EN
  input  logic [2:0]        bright,
`endif
  output logic              commit_pending,
  output logic              wr_err,
  output logic              frame_done,
  output logic [N_COLS-1:0] col_o,
  output logic [N_ROWS-1:0] row_n_o
);

  localparam int CW = $clog2(SCAN_DIV + BLANK_CYC + 1);

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_n;
  logic [2:0]        idx;
  logic [2:0]        idx_n;
  logic [N_ROWS-1:0] back  [N_COLS];
  logic [N_ROWS-1:0] front [N_COLS];
  logic              drive_end;
  logic              last_col;
  logic              wrap;
  logic              swap;
  logic              wr_ok;
  logic              lit;

  assign last_col  = (idx == 3'(N_COLS - 1));
  assign drive_end = (state == DRIVE) &&
                     (cnt == CW'(SCAN_DIV - 1));
  assign wrap      = enable && drive_end && last_col;
  assign swap      = commit_pending &&
                     ((state == IDLE) || wrap);
  assign wr_ok     = wr_en &&
                     ({1'b0, wr_col} < 4'(N_COLS));

`ifdef MATRIX_DIM_EN
  logic [2:0]  bright_q;
  logic [31:0] dim_lim;

  assign dim_lim = (32'(bright_q) + 32'd1) *
                   32'(SCAN_DIV / 8);
  assign lit     = (32'(cnt) < dim_lim);

  // Latch brightness once per column, on DRIVE entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bright_q <= 3'd7;
    end else if (state == BLANK &&
                 state_n == DRIVE) begin
      bright_q <= bright;
    end
  end
`else
  assign lit = 1'b1;
`endif

  // Scan state, dwell counter and column index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
    end
  end

  // Next-state: disable always wins and resets the scan position
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    if (!enable) begin
      state_n = IDLE;
      cnt_n   = '0;
      idx_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_n = BLANK;
          cnt_n   = '0;
          idx_n   = '0;
        end
        BLANK: begin
          if (cnt == CW'(BLANK_CYC - 1)) begin
            state_n = DRIVE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        DRIVE: begin
          if (drive_end) begin
            state_n = BLANK;
            cnt_n   = '0;
            idx_n   = last_col ? 3'd0 : idx + 3'd1;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
          idx_n   = '0;
        end
      endcase
    end
  end

  // Back buffer takes writes; front copies the pre-write back on swap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_COLS; i++) begin
        back[i]  <= '0;
        front[i] <= '0;
      end
    end else begin
      if (wr_ok) begin
        back[wr_col] <= wr_rows;
      end
      if (swap) begin
        for (int i = 0; i < N_COLS; i++) begin
          front[i] <= back[i];
        end
      end
    end
  end

  // Status flags; a fresh commit re-arms pending even on a swap edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_pending <= 1'b0;
      wr_err         <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      commit_pending <= commit |
                        (commit_pending & ~swap);
      wr_err         <= wr_en & ~wr_ok;
      frame_done     <= wrap;
    end
  end

  // Registered pin drive, one cycle behind the scan state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_o   <= '0;
      row_n_o <= '1;
    end else if (enable && state == DRIVE) begin
      col_o   <= N_COLS'(1) << idx;
      row_n_o <= lit ? ~front[idx] : '1;
    end else begin
      col_o   <= '0;
      row_n_o <= '1;
    end
  end

endmodule

// File: tb/tb_led_matrix_scan_driver.sv
// Scoreboard bench for led_matrix_scan_driver (SCAN_DIV=8, BLANK_CYC=2).
// Define MATRIX_DIM_EN to also exercise the brightness input.
module tb_led_matrix_scan_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_col = 3'd0;
  logic [6:0] wr_rows = 7'd0;
  logic       commit = 1'b0;
`ifdef MATRIX_DIM_EN
  logic [2:0] bright = 3'd7;
`endif
  logic       commit_pending;
  logic       wr_err;
  logic       frame_done;
  logic [4:0] col_o;
  logic [6:0] row_n_o;

  int total = 0;
  int bad = 0;

  typedef struct {
    int         col;
    logic [6:0] rn;
    int         fd;
    int         lit;
  } exp_t;

  exp_t sb[$];

  led_matrix_scan_driver #(
    .N_COLS   (5),
    .N_ROWS   (7),
    .SCAN_DIV (8),
    .BLANK_CYC(2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .wr_en         (wr_en),
    .wr_col        (wr_col),
    .wr_rows       (wr_rows),
    .commit        (commit),
`ifdef MATRIX_DIM_EN
    .bright        (bright),
`endif
    .commit_pending(commit_pending),
    .wr_err        (wr_err),
    .frame_done    (frame_done),
    .col_o         (col_o),
    .row_n_o       (row_n_o)
  );

  always #5 clk = ~clk;

  function automatic void push(input int c,
                               input logic [6:0] rn,
                               input int fd,
                               input int lit);
    exp_t e;
    e.col = c;
    e.rn  = rn;
    e.fd  = fd;
    e.lit = lit;
    sb.push_back(e);
  endfunction

  task automatic wait_col(input int c);
    logic [4:0] want;
    int t;
    want = 5'(1) << c;
    t = 0;
    total++;
    while (col_o !== want && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      bad++;
      $display("FAIL wait_col%0d got=%b want=%b",
               c, col_o, want);
    end
  endtask

  task automatic write(input int c,
                       input logic [6:0] rows,
                       input logic cm);
    wr_en   = 1'b1;
    wr_col  = 3'(c);
    wr_rows = rows;
    commit  = cm;
    @(negedge clk);
    wr_en  = 1'b0;
    commit = 1'b0;
  endtask

  task automatic check_cols(input int n);
    exp_t       e;
    logic [4:0] got_col;
    logic [4:0] want_col;
    logic [6:0] got_rn;
    int         t;
    int         len;
    int         lit;
    int         fd;
    for (int k = 0; k < n; k++) begin
      e = sb.pop_front();
      t = 0;
      while (col_o !== 5'd0 && t < 200) begin
        @(negedge clk);
        t++;
      end
      while (col_o === 5'd0 && t < 200) begin
        @(negedge clk);
        t++;
      end
      total++;
      if (t >= 200) begin
        bad++;
        $display("FAIL col_timeout idx=%0d", e.col);
        return;
      end
      got_col = col_o;
      got_rn  = row_n_o;
      len = 0;
      lit = 0;
      fd  = 0;
      while (col_o === got_col && len < 200) begin
        len++;
        if (row_n_o !== 7'h7F) lit++;
        if (frame_done === 1'b1) fd++;
        @(negedge clk);
      end
      want_col = 5'(1) << e.col;
      total++;
      if (got_col !== want_col) begin
        bad++;
        $display("FAIL col_o got=%b want=%b",
                 got_col, want_col);
      end
      total++;
      if (got_rn !== e.rn) begin
        bad++;
        $display("FAIL row_n col%0d got=%h want=%h",
                 e.col, got_rn, e.rn);
      end
      total++;
      if (len !== 8) begin
        bad++;
        $display("FAIL dwell col%0d got=%0d want=8",
                 e.col, len);
      end
      total++;
      if (lit !== e.lit) begin
        bad++;
        $display("FAIL lit col%0d got=%0d want=%0d",
                 e.col, lit, e.lit);
      end
      total++;
      if (fd !== e.fd) begin
        bad++;
        $display("FAIL frame_done col%0d got=%0d want=%0d",
                 e.col, fd, e.fd);
      end
    end
  endtask

  task automatic test_reset();
    int nonblank;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (col_o !== 5'd0 || row_n_o !== 7'h7F ||
        commit_pending !== 1'b0 || wr_err !== 1'b0 ||
        frame_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_state col=%b row=%h p=%b e=%b f=%b",
               col_o, row_n_o, commit_pending,
               wr_err, frame_done);
    end
    write(0, 7'h01, 1'b1);
    enable = 1'b1;
    wait_col(0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (col_o !== 5'd0 || row_n_o !== 7'h7F) begin
      bad++;
      $display("FAIL async_reset col=%b row=%h want 0/7f",
               col_o, row_n_o);
    end
    @(negedge clk);
    enable = 1'b0;
    rst_n = 1'b1;
    nonblank = 0;
    repeat (12) begin
      @(negedge clk);
      if (col_o !== 5'd0 || row_n_o !== 7'h7F ||
          commit_pending !== 1'b0) nonblank++;
    end
    total++;
    if (nonblank !== 0) begin
      bad++;
      $display("FAIL post_reset_blank got=%0d want=0",
               nonblank);
    end
    enable = 1'b1;
    push(0, 7'h7F, 0, 0);
    push(1, 7'h7F, 0, 0);
    check_cols(2);
    enable = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_basic_frame();
    write(0, 7'h01, 1'b0);
    write(2, 7'h40, 1'b1);
    total++;
    if (commit_pending !== 1'b1) begin
      bad++;
      $display("FAIL pend_set got=%b want=1", commit_pending);
    end
    @(negedge clk);
    total++;
    if (commit_pending !== 1'b0) begin
      bad++;
      $display("FAIL idle_swap got=%b want=0", commit_pending);
    end
    enable = 1'b1;
    push(0, 7'h7E, 0, 8);
    push(1, 7'h7F, 0, 0);
    push(2, 7'h3F, 0, 8);
    push(3, 7'h7F, 0, 0);
    push(4, 7'h7F, 1, 0);
    push(0, 7'h7E, 0, 8);
    check_cols(6);
  endtask

  task automatic test_deferred_swap();
    wait_col(1);
    write(0, 7'h7F, 1'b1);
    total++;
    if (commit_pending !== 1'b1) begin
      bad++;
      $display("FAIL defer_pend got=%b want=1", commit_pending);
    end
    push(2, 7'h3F, 0, 8);
    push(3, 7'h7F, 0, 0);
    push(4, 7'h7F, 1, 0);
    push(0, 7'h00, 0, 8);
    check_cols(4);
    total++;
    if (commit_pending !== 1'b0) begin
      bad++;
      $display("FAIL defer_clear got=%b want=0", commit_pending);
    end
    push(1, 7'h7F, 0, 0);
    check_cols(1);
  endtask

  task automatic test_coincident();
    wait_col(2);
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    total++;
    if (commit_pending !== 1'b1) begin
      bad++;
      $display("FAIL pre_wrap_pend got=%b want=1",
               commit_pending);
    end
    wait_col(4);
    repeat (6) @(negedge clk);
    write(3, 7'h55, 1'b1);
    total++;
    if (frame_done !== 1'b1 || commit_pending !== 1'b1) begin
      bad++;
      $display("FAIL wrap_coinc fd=%b p=%b want 1/1",
               frame_done, commit_pending);
    end
    push(0, 7'h00, 0, 8);
    push(1, 7'h7F, 0, 0);
    push(2, 7'h3F, 0, 8);
    push(3, 7'h7F, 0, 0);
    push(4, 7'h7F, 1, 0);
    push(0, 7'h00, 0, 8);
    push(1, 7'h7F, 0, 0);
    push(2, 7'h3F, 0, 8);
    push(3, 7'h2A, 0, 8);
    check_cols(9);
    total++;
    if (commit_pending !== 1'b0) begin
      bad++;
      $display("FAIL coinc_clear got=%b want=0",
               commit_pending);
    end
  endtask

  task automatic test_bad_write_disable();
    int nonblank;
    write(5, 7'h12, 1'b0);
    total++;
    if (wr_err !== 1'b1) begin
      bad++;
      $display("FAIL wr_err5 got=%b want=1", wr_err);
    end
    @(negedge clk);
    total++;
    if (wr_err !== 1'b0) begin
      bad++;
      $display("FAIL wr_err_pulse got=%b want=0", wr_err);
    end
    write(7, 7'h33, 1'b0);
    total++;
    if (wr_err !== 1'b1) begin
      bad++;
      $display("FAIL wr_err7 got=%b want=1", wr_err);
    end
    wait_col(2);
    repeat (3) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    total++;
    if (col_o !== 5'd0 || row_n_o !== 7'h7F) begin
      bad++;
      $display("FAIL disable col=%b row=%h want 0/7f",
               col_o, row_n_o);
    end
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    nonblank = 0;
    repeat (4) begin
      @(negedge clk);
      if (col_o !== 5'd0 || row_n_o !== 7'h7F) nonblank++;
    end
    total++;
    if (nonblank !== 0 || commit_pending !== 1'b0) begin
      bad++;
      $display("FAIL idle_hold nb=%0d p=%b want 0/0",
               nonblank, commit_pending);
    end
    enable = 1'b1;
    push(0, 7'h00, 0, 8);
    push(1, 7'h7F, 0, 0);
    push(2, 7'h3F, 0, 8);
    push(3, 7'h2A, 0, 8);
    push(4, 7'h7F, 1, 0);
    check_cols(5);
  endtask

`ifdef MATRIX_DIM_EN
  task automatic test_dimming();
    enable = 1'b0;
    bright = 3'd1;
    repeat (3) @(negedge clk);
    enable = 1'b1;
    push(0, 7'h00, 0, 2);
    push(1, 7'h7F, 0, 0);
    check_cols(2);
    enable = 1'b0;
    bright = 3'd7;
    repeat (3) @(negedge clk);
    enable = 1'b1;
    push(0, 7'h00, 0, 8);
    check_cols(1);
  endtask
`endif

  initial begin
    test_reset();
    test_basic_frame();
    test_deferred_swap();
    test_coincident();
    test_bad_write_disable();
`ifdef MATRIX_DIM_EN
    test_dimming();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_matrix_scan_driver.md
Name: led_matrix_scan_driver

Overview:
- Sequential column-scan driver for the board LED matrix (5 columns M1_C0..C4 x 7 rows M1_L0..L6); it is the consumer of the row patterns produced by the access/functionality decoders.
- Decoders write per-column row patterns into a back buffer, then commit. The driver swaps the buffers at a frame boundary and multiplexes columns with dead-time blanking.
- Pin polarity matches the board: columns active-high, rows active-low (row pin 0 = LED lit).

Parameters:
- N_COLS, 5, number of matrix columns (max 8).
- N_ROWS, 7, number of matrix rows.
- SCAN_DIV, 50000, clk cycles each column is driven (DRIVE dwell). Must be >=8 and a multiple of 8.
- BLANK_CYC, 2, clk cycles with all columns off between columns (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  scan enable; 0 forces IDLE.
- wr_en  in  1  write strobe into the back buffer.
- wr_col  in  3  column index for the write.
- wr_rows  in  N_ROWS  row pattern; bit r = 1 means LED (col, r) on.
- commit  in  1  1-cycle request to publish the back buffer.
- commit_pending  out  1  high from commit until the swap completes.
- wr_err  out  1  1-cycle pulse when wr_en has wr_col >= N_COLS.
- frame_done  out  1  1-cycle pulse at the end of column N_COLS-1 DRIVE.
- col_o  out  N_COLS  one-hot active-high column drive (M1_C*).
- row_n_o  out  N_ROWS  active-low row drive (M1_L*).

Behaviour:
- Reset (async, rst_n=0): both buffers cleared, col index 0, state IDLE, col_o=0, row_n_o=all 1, commit_pending=0, wr_err=0, frame_done=0. All outputs are registered.
- Writes: when wr_en=1 and wr_col<N_COLS, back[wr_col] <= wr_rows at the next edge. When wr_col>=N_COLS, the write is ignored and wr_err pulses on the next cycle. Writes never touch the front buffer.
- commit=1 sets commit_pending on the next edge.
- FSM states: IDLE, BLANK, DRIVE.
- IDLE: col_o=0, row_n_o=all 1. If commit_pending=1, front <= back and pending clears next cycle. If enable=1, go to BLANK with col index 0.
- BLANK: col_o=0, row_n_o=all 1 for BLANK_CYC cycles, then DRIVE.
- DRIVE: col_o has only bit [idx] set; row_n_o = ~front[idx]; lasts SCAN_DIV cycles.
  - At the end of DRIVE with idx<N_COLS-1: idx++ and go to BLANK.
  - At the end of DRIVE with idx=N_COLS-1: frame_done pulses, idx wraps to 0, go to BLANK. If commit_pending=1 at this point, front <= back on the same edge and pending clears.
- Swap/commit coincidence: commit in the same cycle as a swap sets pending again (new request is not lost).
- Swap/write coincidence: a write in the same cycle as a swap lands in back only; front takes the pre-write back contents.
- enable=0 in any state: next cycle is IDLE, outputs blank, idx=0, dwell counters cleared. Re-enable always restarts at BLANK col 0.
- Output timing: a column is first visible on col_o one cycle after entering DRIVE; no output glitches occur between states.

Optional Feature:
- Macro MATRIX_DIM_EN.
- Defined: adds input bright [2:0]. During DRIVE, row_n_o = ~front[idx] only while the dwell count < (bright+1)*(SCAN_DIV/8); for the rest of the dwell, row_n_o = all 1 while col_o stays asserted.
  - bright is sampled at DRIVE entry.
  - bright=7 gives the full dwell.
- Not defined: the port is absent and rows are driven for the full SCAN_DIV.

Test Plan:
- All bench runs use SCAN_DIV=8, BLANK_CYC=2.
- Reset check: assert rst_n=0 mid-DRIVE -> col_o=0, row_n_o=7'h7F immediately; after release with enable=0, outputs stay blank and commit_pending=0.
- Basic frame:
  - Stimulus: write col0=7'h01, col2=7'h40, commit, enable=1.
  - Required: swap in IDLE; sequence 2 blank cycles, col_o=5'b00001 with row_n_o=7'h7E for 8 cycles, blank, col1 with 7'h7F, blank, col2 with 7'h3F.
  - frame_done pulses after col4, then col0 repeats.
- Deferred swap: while scanning col1, write col0=7'h7F and commit -> commit_pending=1; col0 still shows the old pattern until the wrap; on the next frame col0 row_n_o=7'h00 and pending=0.
- Coincident events: commit and write col3=7'h55 on the exact wrap cycle -> front col3 keeps the old value, commit_pending stays 1, and the next wrap publishes 7'h55 (row_n_o=7'h2A).
- Bad write and disable: wr_col=5 -> wr_err pulses once and no buffer change; drop enable mid-col2 -> blank next cycle, and re-enable restarts at col0.
- Dimming (MATRIX_DIM_EN): bright=1 -> rows active for 2 of 8 DRIVE cycles; bright=7 -> 8 of 8.
